fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_if.sv | 29 ++
 rtl/fifo_rd_stream.sv | 101 ++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read-side and stream handshake bundle
interface fifo_rd_stream_if #(
   parameter int Data_width = 8
);
   logic                  fifo_empty;
   logic [Data_width-1:0] fifo_rd_data;
   logic                  fifo_rd_en;
   logic                  out_valid;
   logic [Data_width-1:0] out_data;
   logic                  out_ready;

   modport master (
      input  fifo_empty,
      input  fifo_rd_data,
      input  out_ready,
      output fifo_rd_en,
      output out_valid,
      output out_data
   );

   modport slave (
      output fifo_empty,
      output fifo_rd_data,
      output out_ready,
      input  fifo_rd_en,
      input  out_valid,
      input  out_data
   );
endinterface

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read port to valid/ready stream with 2-entry skid buffer
module fifo_rd_stream #(
   parameter int Data_width = 8,
   parameter int Cnt_width  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_rd_stream_if.master     bus,
   output logic [Cnt_width-1:0] delivered_cnt
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL2 = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  inflight;
   logic [Data_width-1:0] head;
   logic [Data_width-1:0] head_nxt;
   logic [Data_width-1:0] second;
   logic [Data_width-1:0] second_nxt;
   logic                  push;
   logic                  pop;
   logic [1:0]            occ;
   logic [2:0]            pending;

   assign push          = inflight;
   assign bus.out_valid = (state != EMPTY);
   assign bus.out_data  = head;
   assign pop           = bus.out_valid && bus.out_ready;

   assign occ = (state == FULL2) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);

   // A read is only issued if its word is guaranteed a slot once it lands.
   assign pending = {1'b0, occ} + {2'b00, inflight};
   assign bus.fifo_rd_en = !rst && !bus.fifo_empty && (pending < (3'd2 + {2'b00, pop}));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      head_nxt   = head;
      second_nxt = second;
      case (state)
         EMPTY: begin
            if (push) begin
               state_nxt = ONE;
               head_nxt  = bus.fifo_rd_data;
            end
         end
         ONE: begin
            if (push && !pop) begin
               state_nxt  = FULL2;
               second_nxt = bus.fifo_rd_data;
            end else if (push && pop) begin
               head_nxt = bus.fifo_rd_data;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         FULL2: begin
            if (pop) begin
               head_nxt = second;
               if (push) begin
                  second_nxt = bus.fifo_rd_data;
               end else begin
                  state_nxt = ONE;
               end
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase
   end

   // Reset also drops the word of any read still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight      <= 1'b0;
         head          <= '0;
         second        <= '0;
         delivered_cnt <= '0;
      end else begin
         inflight <= bus.fifo_rd_en;
         head     <= head_nxt;
         second   <= second_nxt;
         if (pop) begin
            delivered_cnt <= delivered_cnt + 1'b1;
         end
      end
   end
endmodule
